mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_defs.sv | 19 +
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_wb_reg.sv | 34 +++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: control-bit positions, FSM encoding, datapath widths.
package pipeline_defs;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 2;

  // Bit positions inside WB = {RegWrite, MemtoReg} and M = {MemRead, MemWrite}
  localparam bit [0:0] REGWRITE = 1'b1;
  localparam bit [0:0] MEMTOREG = 1'b0;
  localparam bit [0:0] MEMREAD  = 1'b1;
  localparam bit [0:0] MEMWRITE = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_stage_if;
  import pipeline_defs::*;

  logic              dm_req;
  logic              dm_we;
  logic [WORD_W-1:0] dm_addr;
  logic [WORD_W-1:0] dm_wdata;
  logic              dm_ready;
  logic              dm_rvalid;
  logic [WORD_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a new entry, inserts a bubble, or holds.
module mem_wb_reg
  import pipeline_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [CTRL_W-1:0] wb_in,
  input  logic [WORD_W-1:0] rdata_in,
  input  logic [WORD_W-1:0] alu_in,
  input  logic [REG_W-1:0]  reg_in,
  output logic [CTRL_W-1:0] wb_q,
  output logic [WORD_W-1:0] rdata_q,
  output logic [WORD_W-1:0] alu_q,
  output logic [REG_W-1:0]  reg_q
);

  // Bubble wins over load so a stalled instruction never writes back twice.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      reg_q   <= '0;
    end else if (load) begin
      wb_q    <= wb_in;
      rdata_q <= rdata_in;
      alu_q   <= alu_in;
      reg_q   <= reg_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls until completion,
// flags illegal/misaligned accesses and feeds the MEM/WB register.
module mem_stage
  import pipeline_defs::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] WB,
  input  logic [CTRL_W-1:0] M,
  input  logic [WORD_W-1:0] ALU_out,
  input  logic [WORD_W-1:0] Wdata,
  input  logic [REG_W-1:0]  writeReg,
  mem_stage_if.master       dm,
  output logic              stall,
  output logic              mem_err,
  output logic [CTRL_W-1:0] WB_ctrl,
  output logic [WORD_W-1:0] WB_rdata,
  output logic [WORD_W-1:0] WB_ALU_out,
  output logic [REG_W-1:0]  WB_writeReg
);

  mem_state_t        state;
  logic              is_mem;
  logic              misaligned;
  logic              illegal;
  logic              legal_mem;
  logic              store_done;
  logic              load_done;
  logic              done;
  logic              wb_load;
  logic [CTRL_W-1:0] wb_in;
  logic [WORD_W-1:0] rdata_in;

  // Access classification; M=11 is never a valid encoding.
  assign is_mem     = (M != 2'b00);
  assign misaligned = ALIGN_CHECK && (ALU_out[1:0] != 2'b00);
  assign illegal    = (M == 2'b11) || (is_mem && misaligned);
  assign legal_mem  = is_mem && !illegal;

  // Request is offered only while idle; held until the memory accepts it.
  assign dm.dm_req   = !rst && (state == ST_IDLE) && legal_mem;
  assign dm.dm_we    = M[MEMWRITE];
  assign dm.dm_addr  = ALU_out;
  assign dm.dm_wdata = Wdata;

  // Stores complete on acceptance; loads complete on returned data.
  assign store_done = (state == ST_IDLE) && legal_mem && M[MEMWRITE] && dm.dm_ready;
  assign load_done  = (state == ST_WAIT_RD) && dm.dm_rvalid;
  assign done       = store_done || load_done;

  assign stall = !rst && legal_mem && !done;

  // Non-memory ops and completed accesses advance; everything else is a bubble.
  assign wb_load  = !is_mem || (legal_mem && done);
  assign wb_in    = {WB[REGWRITE], WB[MEMTOREG]};
  assign rdata_in = load_done ? dm.dm_rdata : '0;

  // Load-wait FSM and registered error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mem_err <= 1'b0;
    end else begin
      mem_err <= illegal;
      case (state)
        ST_IDLE:
          if (dm.dm_req && dm.dm_ready && !dm.dm_we) state <= ST_WAIT_RD;
        ST_WAIT_RD:
          if (dm.dm_rvalid) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (wb_load),
    .bubble   (!wb_load),
    .wb_in    (wb_in),
    .rdata_in (rdata_in),
    .alu_in   (ALU_out),
    .reg_in   (writeReg),
    .wb_q     (WB_ctrl),
    .rdata_q  (WB_rdata),
    .alu_q    (WB_ALU_out),
    .reg_q    (WB_writeReg)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction stream checked against a per-instruction reference model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  WB;
  logic [1:0]  M;
  logic [31:0] ALU_out;
  logic [31:0] Wdata;
  logic [4:0]  writeReg;
  logic        stall;
  logic        mem_err;
  logic [1:0]  WB_ctrl;
  logic [31:0] WB_rdata;
  logic [31:0] WB_ALU_out;
  logic [4:0]  WB_writeReg;

  int checks = 0;
  int errors = 0;

  mem_stage_if dm_bus ();

  mem_stage #(.ALIGN_CHECK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .WB          (WB),
    .M           (M),
    .ALU_out     (ALU_out),
    .Wdata       (Wdata),
    .writeReg    (writeReg),
    .dm          (dm_bus),
    .stall       (stall),
    .mem_err     (mem_err),
    .WB_ctrl     (WB_ctrl),
    .WB_rdata    (WB_rdata),
    .WB_ALU_out  (WB_ALU_out),
    .WB_writeReg (WB_writeReg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage. Memory accepts after rdy_d refused
  // cycles; load data arrives rv_d cycles after the cycle following acceptance.
  // Entered and left at posedge+1.
  task automatic run_instr(input logic [1:0] wb, input logic [1:0] m,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] wreg, input int rdy_d, input int rv_d,
                           input logic [31:0] rdata);
    bit illegal, legal_mem, is_load;
    int total;
    int vcyc;
    illegal   = (m == 2'b11) || (m != 2'b00 && addr[1:0] != 2'b00);
    legal_mem = (m != 2'b00) && !illegal;
    is_load   = legal_mem && (m == 2'b10);
    vcyc      = rdy_d + 1 + rv_d;
    total     = !legal_mem ? 0 : (is_load ? vcyc : rdy_d);
    WB = wb; M = m; ALU_out = addr; Wdata = wdata; writeReg = wreg;
    for (int c = 0; ; c++) begin
      if (!legal_mem)      dm_bus.dm_ready = 1'($urandom);
      else if (c < rdy_d)  dm_bus.dm_ready = 1'b0;
      else if (c == rdy_d) dm_bus.dm_ready = 1'b1;
      else                 dm_bus.dm_ready = 1'($urandom);
      if (is_load) dm_bus.dm_rvalid = (c == vcyc) ? 1'b1 : (c <= rdy_d ? 1'($urandom) : 1'b0);
      else         dm_bus.dm_rvalid = 1'($urandom);
      dm_bus.dm_rdata = (is_load && c == vcyc) ? rdata : $urandom;
      @(negedge clk);
      check("stall", 32'(stall), 32'(c < total));
      check("dm_req", 32'(dm_bus.dm_req), 32'(legal_mem && c <= rdy_d));
      if (legal_mem && c <= rdy_d) begin
        check("dm_addr", dm_bus.dm_addr, addr);
        check("dm_we", 32'(dm_bus.dm_we), 32'(m[0]));
        if (m[0]) check("dm_wdata", dm_bus.dm_wdata, wdata);
      end
      if (c >= total) break;
      @(posedge clk); #1;
      check("bubble_ctrl", 32'(WB_ctrl), 32'd0);
      check("bubble_alu", WB_ALU_out, 32'd0);
    end
    @(posedge clk); #1;
    check("WB_ctrl", 32'(WB_ctrl), illegal ? 32'd0 : 32'(wb));
    check("WB_ALU_out", WB_ALU_out, illegal ? 32'd0 : addr);
    check("WB_writeReg", 32'(WB_writeReg), illegal ? 32'd0 : 32'(wreg));
    check("WB_rdata", WB_rdata, is_load ? rdata : 32'd0);
    check("mem_err", 32'(mem_err), 32'(illegal));
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    WB = 2'b11; M = 2'b10; ALU_out = 32'h100; Wdata = 32'h0; writeReg = 5'd3;
    dm_bus.dm_ready = 1'b1; dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h1111_2222;

    // Reset: outputs cleared, request and stall forced low
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    @(posedge clk); #1;
    check("rst_WB_ctrl", 32'(WB_ctrl), 32'd0);
    check("rst_WB_rdata", WB_rdata, 32'd0);
    check("rst_WB_ALU_out", WB_ALU_out, 32'd0);
    check("rst_WB_writeReg", 32'(WB_writeReg), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    // Non-memory op, single-cycle latency
    run_instr(2'b10, 2'b00, 32'h1234, 32'h0, 5'd7, 0, 0, 32'h0);
    // Store refused twice then accepted
    run_instr(2'b00, 2'b01, 32'h40, 32'hDEADBEEF, 5'd0, 2, 0, 32'h0);
    // Load accepted at once, data three cycles later
    run_instr(2'b11, 2'b10, 32'h80, 32'h0, 5'd9, 0, 2, 32'hCAFEF00D);
    // Misaligned load and M=11
    run_instr(2'b11, 2'b10, 32'h82, 32'h0, 5'd4, 0, 0, 32'h0);
    run_instr(2'b10, 2'b11, 32'h84, 32'h5, 5'd5, 0, 0, 32'h0);
    // Store immediately followed by load
    run_instr(2'b00, 2'b01, 32'h200, 32'hA5A5A5A5, 5'd0, 0, 0, 32'h0);
    run_instr(2'b11, 2'b10, 32'h204, 32'h0, 5'd12, 0, 0, 32'h0BADBEEF);

    // Reset while waiting for load data
    WB = 2'b11; M = 2'b10; ALU_out = 32'h300; writeReg = 5'd6;
    dm_bus.dm_ready = 1'b1; dm_bus.dm_rvalid = 1'b0;
    @(negedge clk);
    check("wr_req", 32'(dm_bus.dm_req), 32'd1);
    @(posedge clk); #1;
    dm_bus.dm_ready = 1'b0;
    @(negedge clk);
    check("wr_stall", 32'(stall), 32'd1);
    check("wr_req_low", 32'(dm_bus.dm_req), 32'd0);
    rst = 1'b1;
    #1;
    check("wr_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("wr_rst_WB_ctrl", 32'(WB_ctrl), 32'd0);
    check("wr_rst_WB_rdata", WB_rdata, 32'd0);
    WB = 2'b00; M = 2'b00; ALU_out = 32'h0; writeReg = 5'd0;
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("late_rvalid_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("late_rvalid_rdata", WB_rdata, 32'd0);
    dm_bus.dm_rvalid = 1'b0;
    run_instr(2'b11, 2'b10, 32'h304, 32'h0, 5'd8, 1, 1, 32'h12345678);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(2'($urandom), 2'($urandom), a, $urandom, 5'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
